// File: rtl/wb_hazard_tracker_pkg.sv
// Shared constants, entry record and helpers for the writeback hazard tracker.
package wb_hazard_tracker_pkg;

  // Opcode / funct fields that produce a register writeback
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  // Writeback data source encodings
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;

  // Cycles after entering E until the result exists, per instruction class
  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_MEM = 2'd2;
  localparam logic [1:0] TNEW_PC8 = 2'd0;

  // Entry record field widths
  localparam int ADDR_W = 5;
  localparam int WDT_W  = 2;
  localparam int TNEW_W = 2;
  localparam int FSEL_W = 3;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [WDT_W-1:0]  wd_type;
    logic [ADDR_W-1:0] addr;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  // Saturating decrement of a result-ready countdown
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == 2'd0) ? 2'd0 : (t - 2'd1);
  endfunction

  // Entry as seen one stage further down the pipeline
  function automatic entry_t age_entry(input entry_t e);
    entry_t r;
    r      = e;
    r.tnew = tnew_dec(e.tnew);
    return r;
  endfunction

endpackage

// File: rtl/wb_hazard_tracker_dest_decode.sv
// Combinational decode of the D-stage instruction into its writeback intent.
module wb_dest_decode
  import wb_hazard_tracker_pkg::*;
(
  input  logic [31:0]       ins,
  output logic              we,
  output logic [WDT_W-1:0]  wd_type,
  output logic [ADDR_W-1:0] addr,
  output logic [TNEW_W-1:0] tnew
);

  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic              we_s;
  logic [WDT_W-1:0]  wd_type_s;
  logic [ADDR_W-1:0] addr_s;
  logic [TNEW_W-1:0] tnew_s;

  assign op_s    = ins[31:26];
  assign funct_s = ins[5:0];

  // Classify the instruction; anything unrecognised writes nothing
  always_comb begin
    we_s      = 1'b0;
    wd_type_s = WD_ALU;
    addr_s    = 5'd0;
    tnew_s    = 2'd0;
    case (op_s)
      OP_SPECIAL: begin
        if ((funct_s == FN_ADDU) || (funct_s == FN_SUBU)) begin
          we_s   = 1'b1;
          addr_s = ins[15:11];
          tnew_s = TNEW_ALU;
        end else begin
          we_s   = 1'b0;
          addr_s = 5'd0;
        end
      end
      OP_ORI, OP_LUI: begin
        we_s   = 1'b1;
        addr_s = ins[20:16];
        tnew_s = TNEW_ALU;
      end
      OP_LW: begin
        we_s      = 1'b1;
        wd_type_s = WD_MEM;
        addr_s    = ins[20:16];
        tnew_s    = TNEW_MEM;
      end
      OP_JAL: begin
        we_s      = 1'b1;
        wd_type_s = WD_PC8;
        addr_s    = 5'd31;
        tnew_s    = TNEW_PC8;
      end
      default: begin
        we_s      = 1'b0;
        wd_type_s = WD_ALU;
        addr_s    = 5'd0;
        tnew_s    = 2'd0;
      end
    endcase
  end

  // A write to $0 is architecturally a no-op, so it never creates a hazard
  assign we      = we_s && (addr_s != 5'd0);
  assign wd_type = wd_type_s;
  assign addr    = addr_s;
  assign tnew    = tnew_s;

endmodule

// File: rtl/wb_hazard_tracker.sv
// Tracks in-flight register writes E..W, generates D-stage stall/bypass
// selects and drives the register-file writeback controls from the W entry.
module wb_hazard_tracker
  import wb_hazard_tracker_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int NREAD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           d_ins,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [5*NREAD-1:0]    rd_addr,
  input  logic [2*NREAD-1:0]    rd_tuse,
  output logic                  stall,
  output logic [3*NREAD-1:0]    fwd_sel,
  output logic                  w_we,
  output logic [WDT_W-1:0]      w_wd_type,
  output logic [ADDR_W-1:0]     w_addr
);

  logic              dec_we_s;
  logic [WDT_W-1:0]  dec_wd_type_s;
  logic [ADDR_W-1:0] dec_addr_s;
  logic [TNEW_W-1:0] dec_tnew_s;
  entry_t            pipe_s [DEPTH];
  logic [NREAD-1:0]  port_stall_s;
  logic              stall_s;
  entry_t            tail_s;

  wb_dest_decode u_dest_decode (
    .ins     (d_ins),
    .we      (dec_we_s),
    .wd_type (dec_wd_type_s),
    .addr    (dec_addr_s),
    .tnew    (dec_tnew_s)
  );

  // Raw stall is used internally; reset takes priority over it at the edge
  assign stall_s = |port_stall_s;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    entry_t ent_r;
    if (k == 0) begin : g_head
      // E entry: admit the decoded D instruction, or a bubble while stalled
      always_ff @(posedge clk) begin
        if (reset) begin
          ent_r <= '0;
        end else if (stall_s) begin
          ent_r <= '0;
        end else begin
          ent_r <= '{valid: 1'b1, we: dec_we_s, wd_type: dec_wd_type_s,
                     addr: dec_addr_s, tnew: dec_tnew_s};
        end
      end
    end else begin : g_body
      // Later entries: advance from the previous stage, counting down tnew
      always_ff @(posedge clk) begin
        if (reset) begin
          ent_r <= '0;
        end else begin
          ent_r <= age_entry(pipe_s[k-1]);
        end
      end
    end
    assign pipe_s[k] = ent_r;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [ADDR_W-1:0] port_addr_s;
    logic [1:0]        port_tuse_s;
    logic [DEPTH-1:0]  match_s;
    logic              hit_s;
    logic [TNEW_W-1:0] hit_tnew_s;
    logic [FSEL_W-1:0] hit_sel_s;

    assign port_addr_s = rd_addr[5*i +: 5];
    assign port_tuse_s = rd_tuse[2*i +: 2];

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
      assign match_s[k] = rd_en[i] && (port_addr_s != 5'd0) && pipe_s[k].valid &&
                          pipe_s[k].we && (pipe_s[k].addr == port_addr_s);
    end

    // Scan oldest to youngest so the youngest match (lowest k) wins
    always_comb begin
      hit_s      = 1'b0;
      hit_tnew_s = 2'd0;
      hit_sel_s  = 3'd0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        hit_s      = match_s[k] ? 1'b1 : hit_s;
        hit_tnew_s = match_s[k] ? pipe_s[k].tnew : hit_tnew_s;
        hit_sel_s  = match_s[k] ? FSEL_W'(k + 1) : hit_sel_s;
      end
    end

    assign port_stall_s[i]  = hit_s && (hit_tnew_s > port_tuse_s);
    assign fwd_sel[3*i +: 3] = (!reset && hit_s && (hit_tnew_s == 2'd0)) ? hit_sel_s : 3'd0;
  end

  assign tail_s    = pipe_s[DEPTH-1];
  assign stall     = !reset && stall_s;
  assign w_we      = !reset && tail_s.valid && tail_s.we;
  assign w_wd_type = (!reset && tail_s.valid) ? tail_s.wd_type : 2'd0;
  assign w_addr    = (!reset && tail_s.valid) ? tail_s.addr : 5'd0;

endmodule

// File: tb/tb_wb_hazard_tracker.sv
// Directed plus randomized bench for wb_hazard_tracker (DEPTH=3, NREAD=2)
// against a stage-position reference model.
module tb_wb_hazard_tracker;

  localparam int DEPTH = 3;
  localparam int NREAD = 2;

  logic        clk;
  logic        reset;
  logic [31:0] d_ins;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_tuse;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic        w_we;
  logic [1:0]  w_wd_type;
  logic [4:0]  w_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: which instruction word occupies each stage
  bit          m_val [DEPTH];
  logic [31:0] m_ins [DEPTH];
  logic        exp_stall;
  logic [5:0]  exp_fwd;
  logic        exp_w_we;
  logic [1:0]  exp_w_type;
  logic [4:0]  exp_w_addr;

  logic        obs_stall;
  logic [5:0]  obs_fwd;
  logic        obs_w_we;
  logic [1:0]  obs_w_type;
  logic [4:0]  obs_w_addr;

  wb_hazard_tracker #(.DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_ins     (d_ins),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_tuse   (rd_tuse),
    .stall     (stall),
    .fwd_sel   (fwd_sel),
    .w_we      (w_we),
    .w_wd_type (w_wd_type),
    .w_addr    (w_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Instruction-level meaning of a word: who it writes, from where, and when ready
  function automatic void ref_dec(input logic [31:0] ins, output bit we, output int typ,
                                  output int addr, output int tnew);
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    we = 1'b0; typ = 0; addr = 0; tnew = 0;
    if (op == 0 && (fn == 'h21 || fn == 'h23)) begin
      we = 1'b1; addr = int'(ins[15:11]); tnew = 1;
    end else if (op == 'h0d || op == 'h0f) begin
      we = 1'b1; addr = int'(ins[20:16]); tnew = 1;
    end else if (op == 'h23) begin
      we = 1'b1; typ = 1; addr = int'(ins[20:16]); tnew = 2;
    end else if (op == 'h03) begin
      we = 1'b1; typ = 2; addr = 31; tnew = 0;
    end
    if (addr == 0) we = 1'b0;
  endfunction

  task automatic model_eval();
    bit we;
    int typ, addr, tn, t, ra, tuse;
    bit found;
    exp_stall = 1'b0; exp_fwd = 6'd0;
    exp_w_we = 1'b0; exp_w_type = 2'd0; exp_w_addr = 5'd0;
    if (!reset) begin
      for (int i = 0; i < NREAD; i++) begin
        ra    = int'(rd_addr[5*i +: 5]);
        tuse  = int'(rd_tuse[2*i +: 2]);
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && m_val[k] && rd_en[i] && ra != 0) begin
            ref_dec(m_ins[k], we, typ, addr, tn);
            if (we && addr == ra) begin
              found = 1'b1;
              t = (tn > k) ? tn - k : 0;
              if (t > tuse) exp_stall = 1'b1;
              if (t == 0) exp_fwd[3*i +: 3] = 3'(k + 1);
            end
          end
        end
      end
      if (m_val[DEPTH-1]) begin
        ref_dec(m_ins[DEPTH-1], we, typ, addr, tn);
        exp_w_we   = we;
        exp_w_type = 2'(typ);
        exp_w_addr = 5'(addr);
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) m_val[k] = 1'b0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_val[k] = m_val[k-1];
        m_ins[k] = m_ins[k-1];
      end
      m_val[0] = !exp_stall;
      m_ins[0] = d_ins;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive D inputs, compare outputs with the model, then clock
  task automatic step(input logic r, input logic [31:0] ins, input logic [1:0] en,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [1:0] t0, input logic [1:0] t1, input string tag);
    reset = r; d_ins = ins; rd_en = en; rd_addr = {a1, a0}; rd_tuse = {t1, t0};
    #1;
    model_eval();
    obs_stall = stall; obs_fwd = fwd_sel;
    obs_w_we = w_we; obs_w_type = w_wd_type; obs_w_addr = w_addr;
    check({tag, ".stall"},   32'(obs_stall),  32'(exp_stall));
    check({tag, ".fwd_sel"}, 32'(obs_fwd),    32'(exp_fwd));
    check({tag, ".w_we"},    32'(obs_w_we),   32'(exp_w_we));
    check({tag, ".w_type"},  32'(obs_w_type), 32'(exp_w_type));
    check({tag, ".w_addr"},  32'(obs_w_addr), 32'(exp_w_addr));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic nop(input string tag);
    step(1'b0, 32'h0, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, tag);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 8))
      0: return enc_r(6'h21, rs, rt, rd);
      1: return enc_r(6'h23, rs, rt, rd);
      2: return enc_i(6'h0d, rs, rt, 16'h0005);
      3: return enc_i(6'h0f, 5'd0, rt, 16'h1234);
      4: return enc_i(6'h23, rs, rt, 16'h0004);
      5: return {6'h03, 26'h0000100};
      6: return enc_i(6'h04, rs, rt, 16'h0002);
      7: return enc_i(6'h2b, rs, rt, 16'h0008);
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] lw5, addu652, beq5, ori7, jr7, jal0, jr31, addu3, ori3, ori0;
  logic [31:0] r_ins;
  logic [1:0]  r_en, r_t0, r_t1;
  logic [4:0]  r_a0, r_a1;
  logic        r_rst;

  initial begin
    lw5     = enc_i(6'h23, 5'd1, 5'd5, 16'h0000);
    addu652 = enc_r(6'h21, 5'd5, 5'd2, 5'd6);
    beq5    = enc_i(6'h04, 5'd5, 5'd0, 16'h0004);
    ori7    = enc_i(6'h0d, 5'd0, 5'd7, 16'h0001);
    jr7     = enc_r(6'h08, 5'd7, 5'd0, 5'd0);
    jal0    = {6'h03, 26'h0000040};
    jr31    = enc_r(6'h08, 5'd31, 5'd0, 5'd0);
    addu3   = enc_r(6'h21, 5'd1, 5'd2, 5'd3);
    ori3    = enc_i(6'h0d, 5'd1, 5'd3, 16'h0005);
    ori0    = enc_i(6'h0d, 5'd1, 5'd0, 16'h0005);
    for (int k = 0; k < DEPTH; k++) begin m_val[k] = 1'b0; m_ins[k] = 32'h0; end

    // 1. reset with lw in D, then idle
    step(1'b1, lw5, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p1.rst0");
    check("p1.rst0.stall0", 32'(obs_stall), 32'd0);
    step(1'b1, lw5, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p1.rst1");
    check("p1.rst1.w_we0", 32'(obs_w_we), 32'd0);
    check("p1.rst1.w_addr0", 32'(obs_w_addr), 32'd0);
    nop("p1.n0"); nop("p1.n1"); nop("p1.n2");
    check("p1.idle.stall0", 32'(obs_stall), 32'd0);

    // 2. load-use with an ALU consumer
    step(1'b0, lw5, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p2.lw");
    step(1'b0, addu652, 2'b11, 5'd5, 5'd2, 2'd1, 2'd1, "p2.use0");
    check("p2.stall1", 32'(obs_stall), 32'd1);
    step(1'b0, addu652, 2'b11, 5'd5, 5'd2, 2'd1, 2'd1, "p2.use1");
    check("p2.stall_released", 32'(obs_stall), 32'd0);
    check("p2.fwd0", 32'(obs_fwd[2:0]), 32'd0);
    nop("p2.wb");
    check("p2.w_we", 32'(obs_w_we), 32'd1);
    check("p2.w_type", 32'(obs_w_type), 32'd1);
    check("p2.w_addr", 32'(obs_w_addr), 32'd5);
    nop("p2.n0"); nop("p2.n1");

    // 3. branch-operand uses
    step(1'b0, lw5, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p3.lw");
    step(1'b0, beq5, 2'b01, 5'd5, 5'd0, 2'd0, 2'd0, "p3.beq0");
    check("p3.beq0.stall", 32'(obs_stall), 32'd1);
    step(1'b0, beq5, 2'b01, 5'd5, 5'd0, 2'd0, 2'd0, "p3.beq1");
    check("p3.beq1.stall", 32'(obs_stall), 32'd1);
    step(1'b0, beq5, 2'b01, 5'd5, 5'd0, 2'd0, 2'd0, "p3.beq2");
    check("p3.beq2.stall", 32'(obs_stall), 32'd0);
    check("p3.beq2.fwd_w", 32'(obs_fwd[2:0]), 32'd3);
    step(1'b0, ori7, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p3.ori");
    step(1'b0, jr7, 2'b01, 5'd7, 5'd0, 2'd0, 2'd0, "p3.jr0");
    check("p3.jr0.stall", 32'(obs_stall), 32'd1);
    step(1'b0, jr7, 2'b01, 5'd7, 5'd0, 2'd0, 2'd0, "p3.jr1");
    check("p3.jr1.fwd_m", 32'(obs_fwd[2:0]), 32'd2);
    nop("p3.n0"); nop("p3.n1"); nop("p3.n2");

    // 4. jal followed by jr $31
    step(1'b0, jal0, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p4.jal");
    step(1'b0, jr31, 2'b01, 5'd31, 5'd0, 2'd0, 2'd0, "p4.jr");
    check("p4.jr.stall", 32'(obs_stall), 32'd0);
    check("p4.jr.fwd_e", 32'(obs_fwd[2:0]), 32'd1);
    nop("p4.n0"); nop("p4.wb");
    check("p4.w_addr", 32'(obs_w_addr), 32'd31);
    check("p4.w_type", 32'(obs_w_type), 32'd2);
    nop("p4.n1"); nop("p4.n2");

    // 5. shadowing by a younger writer, and writes to $0
    step(1'b0, addu3, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p5.addu");
    step(1'b0, ori3, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p5.ori");
    step(1'b0, 32'h0, 2'b01, 5'd3, 5'd0, 2'd1, 2'd0, "p5.rd3");
    check("p5.shadow.stall", 32'(obs_stall), 32'd0);
    check("p5.shadow.fwd", 32'(obs_fwd[2:0]), 32'd0);
    step(1'b0, ori0, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p5.ori0");
    step(1'b0, 32'h0, 2'b11, 5'd0, 5'd0, 2'd0, 2'd0, "p5.rd0");
    check("p5.zero.stall", 32'(obs_stall), 32'd0);
    check("p5.zero.fwd", 32'(obs_fwd), 32'd0);
    nop("p5.n0"); nop("p5.wb");
    check("p5.zero.w_we", 32'(obs_w_we), 32'd0);
    nop("p5.n1");

    // 6. reset asserted during a load-use stall
    step(1'b0, lw5, 2'b00, 5'd0, 5'd0, 2'd0, 2'd0, "p6.lw");
    step(1'b0, addu652, 2'b01, 5'd5, 5'd0, 2'd1, 2'd0, "p6.use");
    check("p6.stall1", 32'(obs_stall), 32'd1);
    step(1'b1, addu652, 2'b01, 5'd5, 5'd0, 2'd1, 2'd0, "p6.rst");
    check("p6.rst.stall", 32'(obs_stall), 32'd0);
    check("p6.rst.w_we", 32'(obs_w_we), 32'd0);
    step(1'b0, addu652, 2'b01, 5'd5, 5'd0, 2'd1, 2'd0, "p6.admit");
    check("p6.admit.stall", 32'(obs_stall), 32'd0);
    nop("p6.n0"); nop("p6.n1"); nop("p6.wb");
    check("p6.w_we", 32'(obs_w_we), 32'd1);
    check("p6.w_addr", 32'(obs_w_addr), 32'd6);
    check("p6.w_type", 32'(obs_w_type), 32'd0);

    // Randomized traffic; D is held while the model says the pipe is stalled
    r_ins = 32'h0; r_en = 2'b00; r_a0 = 5'd0; r_a1 = 5'd0; r_t0 = 2'd0; r_t1 = 2'd0;
    for (int n = 0; n < 500; n++) begin
      if (!(exp_stall && !r_rst) || n == 0) begin
        r_ins = rand_ins();
        r_en  = 2'($urandom_range(0, 3));
        r_a0  = 5'($urandom_range(0, 3));
        r_a1  = 5'($urandom_range(0, 3));
        r_t0  = 2'($urandom_range(0, 2));
        r_t1  = 2'($urandom_range(0, 2));
      end
      r_rst = ($urandom_range(0, 39) == 0);
      step(r_rst, r_ins, r_en, r_a0, r_a1, r_t0, r_t1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
